// File: rtl/shift_rotate_unit_pkg.sv
// Shared definitions for the shift/rotate unit: op encodings and pipeline split helpers.
package shift_rotate_unit_pkg;

    typedef enum logic [2:0] {
        OP_SHL  = 3'd0,
        OP_SHR  = 3'd1,
        OP_SAR  = 3'd2,
        OP_ROL  = 3'd3,
        OP_ROR  = 3'd4,
        OP_RCL  = 3'd5,
        OP_RCR  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Number of mux levels (low amount bits) applied before the optional mid register.
    function automatic int stage1_levels(input int shw);
        return (shw + 1) / 2;
    endfunction

    // Right-moving ops keep the carry slot below the data ({a, c}); the rest keep it above ({c, a}).
    function automatic logic is_right(input logic [2:0] op);
        return op inside {OP_SHR, OP_SAR, OP_ROR, OP_RCR};
    endfunction

endpackage

// File: rtl/shift_rotate_level.sv
// One barrel level: moves the (WIDTH+1)-bit carry-extended word by 2**LEVEL when i_bit is set.
module shift_rotate_level
    import shift_rotate_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic [WIDTH:0] i_word,
    input  logic [2:0]     i_op,
    input  logic           i_bit,
    output logic [WIDTH:0] o_word
);

    localparam int S = 1 << LEVEL;

    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;

    // Plain rotates move only the data field; the carry slot tracks the bit that wrapped last.
    assign w_rol = {i_word[WIDTH-1-S:0], i_word[WIDTH-1:WIDTH-S]};
    assign w_ror = {i_word[S:1], i_word[WIDTH:S+1]};

    always_comb begin
        // NOTE: default assigned first so every path drives o_word and no latch is inferred.
        o_word = i_word;
        if (i_bit) begin
            unique case (op_e'(i_op))
                OP_SHL:  o_word = i_word << S;
                OP_SHR:  o_word = i_word >> S;
                OP_SAR:  o_word = {{S{i_word[WIDTH]}}, i_word[WIDTH:S]};
                OP_ROL:  o_word = {w_rol[0], w_rol};
                OP_ROR:  o_word = {w_ror, w_ror[WIDTH-1]};
                OP_RCL:  o_word = {i_word[WIDTH-S:0], i_word[WIDTH:WIDTH-S+1]};
                OP_RCR:  o_word = {i_word[S-1:0], i_word[WIDTH:S]};
                OP_PASS: o_word = i_word;
            endcase
        end
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// Pipelined shift/rotate unit: SHW barrel levels, optional mid register, valid/ready on both sides.
module shift_rotate_unit
    import shift_rotate_unit_pkg::*;
#(
    parameter int  WIDTH    = 32,
    parameter int  PIPE_MID = 1,
    parameter int  TAG_W    = 4,
    localparam int SHW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_n,
    input  logic             in_c,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic             out_c,
    output logic             out_z,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SPLIT = stage1_levels(SHW);
    localparam int NHI   = SHW - SPLIT;

    logic [WIDTH:0]     w_s1 [0:SPLIT];
    logic [WIDTH:0]     w_s2 [SPLIT:SHW];
    logic [2:0]         w_s2_op;
    logic [NHI-1:0]     w_s2_nhi;
    logic [TAG_W-1:0]   w_s2_tag;
    logic               w_s2_valid;
    logic               w_out_adv;
    logic               w_right;
    logic [WIDTH-1:0]   w_q;
    logic               w_c;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_q;
    logic               r_out_c;
    logic               r_out_z;
    logic [TAG_W-1:0]   r_out_tag;

    assign w_s1[0] = is_right(in_op) ? {in_a, in_c} : {in_c, in_a};

    for (genvar k = 0; k < SPLIT; k++) begin : g_s1
        shift_rotate_level #(.WIDTH(WIDTH), .LEVEL(k)) u_level (
            .i_word (w_s1[k]),
            .i_op   (in_op),
            .i_bit  (in_n[k]),
            .o_word (w_s1[k+1])
        );
    end

    // The output stage can take new data when empty or being drained this cycle.
    assign w_out_adv = !r_out_valid || out_ready;

    if (PIPE_MID != 0) begin : g_mid
        logic             r_mid_valid;
        logic [WIDTH:0]   r_mid_word;
        logic [2:0]       r_mid_op;
        logic [NHI-1:0]   r_mid_nhi;
        logic [TAG_W-1:0] r_mid_tag;

        assign in_ready = !r_mid_valid || w_out_adv;

        // NOTE: non-blocking assignments for all sequential state so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mid_valid <= 1'b0;
            end else if (in_ready) begin
                r_mid_valid <= in_valid;
            end
        end

        // NOTE: payload flops have no reset; they are only observed while r_mid_valid is set.
        always_ff @(posedge clk) begin
            if (in_ready && in_valid) begin
                r_mid_word <= w_s1[SPLIT];
                r_mid_op   <= in_op;
                r_mid_nhi  <= in_n[SHW-1:SPLIT];
                r_mid_tag  <= in_tag;
            end
        end

        assign w_s2[SPLIT] = r_mid_word;
        assign w_s2_op     = r_mid_op;
        assign w_s2_nhi    = r_mid_nhi;
        assign w_s2_tag    = r_mid_tag;
        assign w_s2_valid  = r_mid_valid;
    end else begin : g_nomid
        assign in_ready    = w_out_adv;
        assign w_s2[SPLIT] = w_s1[SPLIT];
        assign w_s2_op     = in_op;
        assign w_s2_nhi    = in_n[SHW-1:SPLIT];
        assign w_s2_tag    = in_tag;
        assign w_s2_valid  = in_valid;
    end

    for (genvar k = SPLIT; k < SHW; k++) begin : g_s2
        shift_rotate_level #(.WIDTH(WIDTH), .LEVEL(k)) u_level (
            .i_word (w_s2[k]),
            .i_op   (w_s2_op),
            .i_bit  (w_s2_nhi[k-SPLIT]),
            .o_word (w_s2[k+1])
        );
    end

    assign w_right = is_right(w_s2_op);
    assign w_q     = w_right ? w_s2[SHW][WIDTH:1] : w_s2[SHW][WIDTH-1:0];
    assign w_c     = w_right ? w_s2[SHW][0]       : w_s2[SHW][WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_q     <= '0;
            r_out_c     <= 1'b0;
            r_out_z     <= 1'b0;
            r_out_tag   <= '0;
        end else if (w_out_adv) begin
            r_out_valid <= w_s2_valid;
            if (w_s2_valid) begin
                r_out_q   <= w_q;
                r_out_c   <= w_c;
                r_out_z   <= ~|w_q;
                r_out_tag <= w_s2_tag;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_q     = r_out_q;
    assign out_c     = r_out_c;
    assign out_z     = r_out_z;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Self-checking bench: directed cases, stall/reset behaviour, and random sweeps on four configurations.
module tb_shift_rotate_unit;
    import shift_rotate_unit_pkg::*;

    typedef logic [37:0] exp_t;   // {tag, c, z, q}

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  s_op;
    logic [31:0] s_a;
    logic [4:0]  s_n;
    logic        s_c;
    logic [3:0]  s_tag;

    logic        iv   [4];
    logic        ordy [4];
    logic        ir   [4];
    logic        ov   [4];
    logic        oc   [4];
    logic        oz   [4];
    logic [31:0] oq   [4];
    logic [3:0]  ot   [4];
    logic [7:0]  q8_p1;
    logic [7:0]  q8_p0;

    int n_assert = 0;
    int n_fail   = 0;
    exp_t exp_q [$];

    always #5 clk = ~clk;

    shift_rotate_unit #(.WIDTH(32), .PIPE_MID(1), .TAG_W(4)) u_dut_w32_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_op(s_op), .in_a(s_a),
        .in_n(s_n), .in_c(s_c), .in_tag(s_tag), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_q(oq[0]), .out_c(oc[0]), .out_z(oz[0]), .out_tag(ot[0]));

    shift_rotate_unit #(.WIDTH(32), .PIPE_MID(0), .TAG_W(4)) u_dut_w32_p0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_op(s_op), .in_a(s_a),
        .in_n(s_n), .in_c(s_c), .in_tag(s_tag), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_q(oq[1]), .out_c(oc[1]), .out_z(oz[1]), .out_tag(ot[1]));

    shift_rotate_unit #(.WIDTH(8), .PIPE_MID(1), .TAG_W(4)) u_dut_w8_p1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_op(s_op), .in_a(s_a[7:0]),
        .in_n(s_n[2:0]), .in_c(s_c), .in_tag(s_tag), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_q(q8_p1), .out_c(oc[2]), .out_z(oz[2]), .out_tag(ot[2]));

    shift_rotate_unit #(.WIDTH(8), .PIPE_MID(0), .TAG_W(4)) u_dut_w8_p0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .in_op(s_op), .in_a(s_a[7:0]),
        .in_n(s_n[2:0]), .in_c(s_c), .in_tag(s_tag), .out_valid(ov[3]), .out_ready(ordy[3]),
        .out_q(q8_p0), .out_c(oc[3]), .out_z(oz[3]), .out_tag(ot[3]));

    assign oq[2] = {24'h0, q8_p1};
    assign oq[3] = {24'h0, q8_p0};

    // Reference: each op's rule written directly with integer shifts, masks and bit picks.
    function automatic logic [32:0] ref_model(input int w, input logic [2:0] op,
                                              input logic [31:0] a, input int n, input logic c);
        logic [63:0] mask  = (64'd1 << w) - 64'd1;
        logic [63:0] mask1 = (64'd1 << (w + 1)) - 64'd1;
        logic [63:0] a64   = {32'h0, a} & mask;
        logic [63:0] v;
        logic [63:0] q;
        logic        co;
        if (op == OP_PASS || n == 0) return {c, a64[31:0]};
        case (op)
            OP_SHL: begin q = (a64 << n) & mask; co = a64[w-n]; end
            OP_SHR: begin q = a64 >> n; co = a64[n-1]; end
            OP_SAR: begin
                q = a64 >> n;
                if (a64[w-1]) q = q | (mask & ~(mask >> n));
                co = a64[n-1];
            end
            OP_ROL: begin q = ((a64 << n) | (a64 >> (w - n))) & mask; co = q[0]; end
            OP_ROR: begin q = ((a64 >> n) | (a64 << (w - n))) & mask; co = q[w-1]; end
            OP_RCL: begin
                v  = ({63'h0, c} << w) | a64;
                v  = ((v << n) | (v >> (w + 1 - n))) & mask1;
                q  = v & mask;
                co = v[w];
            end
            default: begin
                v  = (a64 << 1) | {63'h0, c};
                v  = ((v >> n) | (v << (w + 1 - n))) & mask1;
                q  = v >> 1;
                co = v[0];
            end
        endcase
        return {co, q[31:0]};
    endfunction

    function automatic exp_t exp_word(input int w, input logic [2:0] op, input logic [31:0] a,
                                      input int n, input logic c, input logic [3:0] tag);
        logic [32:0] r = ref_model(w, op, a, n, c);
        return {tag, r[32], (r[31:0] == 32'h0), r[31:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [4:0] n,
                         input logic c, input logic [3:0] tag);
        s_op = op; s_a = a; s_n = n; s_c = c; s_tag = tag;
    endtask

    // Sends one op to the W32/PIPE_MID=1 unit and returns its result and latency in cycles.
    task automatic run_one(input logic [2:0] op, input logic [31:0] a, input logic [4:0] n,
                           input logic c, input logic [3:0] tag, output exp_t got, output int lat);
        int wait_cyc = 0;
        @(negedge clk);
        drive(op, a, n, c, tag);
        iv[0] = 1'b1; ordy[0] = 1'b1;
        #1;
        while (!ir[0] && wait_cyc < 10) begin @(negedge clk); #1; wait_cyc++; end
        check("accept_within_bound", ir[0], 1'b1);
        @(posedge clk);
        @(negedge clk);
        iv[0] = 1'b0;
        lat = 1;
        while (!ov[0] && lat < 10) begin @(negedge clk); lat++; end
        got = {ot[0], oc[0], oz[0], oq[0]};
    endtask

    task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                            input logic [4:0] n, input logic c, input logic [3:0] tag,
                            input logic [31:0] q_exp, input logic c_exp, input logic z_exp);
        exp_t got;
        int   lat;
        run_one(op, a, n, c, tag, got, lat);
        check({name, "_q"},   got[31:0], q_exp);
        check({name, "_c"},   got[33],   c_exp);
        check({name, "_z"},   got[32],   z_exp);
        check({name, "_tag"}, got[37:34], tag);
        check({name, "_lat"}, lat, 2);
    endtask

    task automatic sweep(input int k, input int w, input int nops);
        int   sent = 0;
        int   got  = 0;
        logic hold = 1'b0;
        exp_t e;
        exp_q.delete();
        for (int cyc = 0; cyc < nops * 8 && got < nops; cyc++) begin
            @(negedge clk);
            if (!hold) begin
                iv[k] = (sent < nops) && ($urandom_range(0, 3) != 0);
                s_op  = 3'($urandom_range(0, 7));
                s_a   = $urandom;
                if (w == 8) s_a = s_a & 32'hFF;
                s_n   = 5'($urandom_range(0, w - 1));
                s_c   = 1'($urandom_range(0, 1));
                s_tag = 4'($urandom_range(0, 15));
            end
            ordy[k] = (sent >= nops) || ($urandom_range(0, 3) != 0);
            #1;
            if (ov[k] && ordy[k]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("sweep%0d_unexpected_out", k), ov[k], 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sweep%0d_w%0d_result", k, w), {ot[k], oc[k], oz[k], oq[k]}, e);
                    got++;
                end
            end
            if (iv[k] && ir[k]) begin
                exp_q.push_back(exp_word(w, s_op, s_a, s_n, s_c, s_tag));
                sent++;
                hold = 1'b0;
            end else begin
                hold = iv[k];
            end
        end
        iv[k] = 1'b0; ordy[k] = 1'b1;
        check($sformatf("sweep%0d_all_received", k), got, nops);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e1, e2, e3, got;
        int   lat;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin iv[i] = 1'b0; ordy[i] = 1'b1; end
        drive(OP_SHL, 32'h0, 5'd0, 1'b0, 4'h0);
        #1;
        check("reset_out_valid", ov[0], 1'b0);
        check("reset_out_q",     oq[0], 32'h0);
        check("reset_out_c",     oc[0], 1'b0);
        check("reset_out_z",     oz[0], 1'b0);
        check("reset_out_tag",   ot[0], 4'h0);
        check("reset_in_ready",  ir[0], 1'b1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        directed("sar",     OP_SAR, 32'h8000_0010, 5'd4, 1'b1, 4'h1, 32'hF800_0001, 1'b0, 1'b0);
        directed("rcr",     OP_RCR, 32'h0000_0001, 5'd1, 1'b1, 4'h2, 32'h8000_0000, 1'b1, 1'b0);
        directed("rcl",     OP_RCL, 32'h8000_0000, 5'd1, 1'b0, 4'h3, 32'h0000_0000, 1'b1, 1'b1);
        directed("rol",     OP_ROL, 32'h8000_0001, 5'd4, 1'b0, 4'h4, 32'h0000_0018, 1'b0, 1'b0);
        directed("shl_n0",  OP_SHL, 32'h0000_0003, 5'd0, 1'b1, 4'h5, 32'h0000_0003, 1'b1, 1'b0);
        directed("pass_n7", OP_PASS, 32'h1234_5678, 5'd7, 1'b0, 4'h6, 32'h1234_5678, 1'b0, 1'b0);

        // Stall with out_ready low: three ops, in_ready drops once tags 1 and 2 occupy the pipe.
        e1 = exp_word(32, OP_ROR, 32'h0000_00F1, 8,  1'b0, 4'h1);
        e2 = exp_word(32, OP_SHR, 32'hA5A5_0000, 16, 1'b1, 4'h2);
        e3 = exp_word(32, OP_RCL, 32'h4000_0001, 31, 1'b1, 4'h3);
        @(negedge clk);
        ordy[0] = 1'b0; iv[0] = 1'b1;
        drive(OP_ROR, 32'h0000_00F1, 5'd8, 1'b0, 4'h1);
        #1 check("stall_ready_tag1", ir[0], 1'b1);
        @(negedge clk);
        drive(OP_SHR, 32'hA5A5_0000, 5'd16, 1'b1, 4'h2);
        #1 check("stall_ready_tag2", ir[0], 1'b1);
        @(negedge clk);
        drive(OP_RCL, 32'h4000_0001, 5'd31, 1'b1, 4'h3);
        #1 check("stall_ready_drop", ir[0], 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("stall_held_out", {ov[0], ot[0], oc[0], oz[0], oq[0]}, {1'b1, e1});
            check("stall_ready_low", ir[0], 1'b0);
        end
        ordy[0] = 1'b1;
        #1;
        check("release_ready_same_cycle", ir[0], 1'b1);
        check("drain_tag1", {ov[0], ot[0], oc[0], oz[0], oq[0]}, {1'b1, e1});
        @(negedge clk);
        iv[0] = 1'b0;
        #1 check("drain_tag2", {ov[0], ot[0], oc[0], oz[0], oq[0]}, {1'b1, e2});
        @(negedge clk);
        #1 check("drain_tag3", {ov[0], ot[0], oc[0], oz[0], oq[0]}, {1'b1, e3});
        @(negedge clk);
        #1 check("drain_empty", ov[0], 1'b0);

        // Reset while one result is held at the output and another sits in the mid stage.
        @(negedge clk);
        ordy[0] = 1'b0; iv[0] = 1'b1;
        drive(OP_PASS, 32'hDEAD_BEEF, 5'd0, 1'b1, 4'h9);
        @(negedge clk);
        drive(OP_SHL, 32'h0000_0F0F, 5'd3, 1'b0, 4'hA);
        @(negedge clk);
        iv[0] = 1'b0;
        #1 check("pre_reset_out_valid", ov[0], 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", ov[0], 1'b0);
        check("async_reset_out_q",     oq[0], 32'h0);
        check("async_reset_out_flags", {ot[0], oc[0], oz[0]}, 6'h0);
        @(negedge clk);
        rst_n = 1'b1; ordy[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("no_replay_after_reset", ov[0], 1'b0);
        end
        run_one(OP_ROR, 32'h0000_0001, 5'd1, 1'b0, 4'hC, got, lat);
        check("post_reset_latency", lat, 2);
        check("post_reset_result", got, exp_word(32, OP_ROR, 32'h0000_0001, 1, 1'b0, 4'hC));

        sweep(0, 32, 400);
        sweep(1, 32, 400);
        sweep(2, 8,  400);
        sweep(3, 8,  400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
- Parametrised, pipelined shift/rotate execution unit for the ALU datapath.
- Replaces the separate fixed-width combinational barrels (RCR, RCL, SAR) with one block covering logical, arithmetic, rotate and rotate-through-carry modes.
- Produces carry and zero flags.
- Valid/ready handshake on input and output, optional mid-pipeline register, and a tag that travels with each operation.

Parameters:
WIDTH, 32, data width in bits; power of two, 8..64
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)
PIPE_MID, 1, 1 = register after the first ceil(SHW/2) mux levels; 0 = none
TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
clk  in  1  clock
rst_n  in  1  reset
in_valid  in  1  operation offered
in_ready  out  1  unit can accept this cycle
in_op  in  3  0 SHL, 1 SHR, 2 SAR, 3 ROL, 4 ROR, 5 RCL, 6 RCR, 7 PASS
in_a  in  WIDTH  operand
in_n  in  SHW  shift amount, 0..WIDTH-1
in_c  in  1  incoming carry flag
in_tag  in  TAG_W  opaque tag
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_q  out  WIDTH  result
out_c  out  1  carry out
out_z  out  1  1 when out_q == 0
out_tag  out  TAG_W  tag of this result

Behaviour:
- Interface: one clock, clk, rising edge; rst_n asynchronous, active-low.
- Reset: out_valid=0, out_q=0, out_c=0, out_z=0, out_tag=0, mid-stage valid=0. Cleared immediately on assertion, not waiting for a clock edge.
- Reset mid-operation: all in-flight operations are discarded; nothing is replayed after reset.
- Transfers: input accepted when in_valid && in_ready; result consumed when out_valid && out_ready.
- Latency: 1 + PIPE_MID cycles from acceptance to out_valid.
- Throughput: one operation per cycle while out_ready=1.
- in_ready = !stage_valid[first] || stage can advance. An advance is propagated combinationally from out_ready, so a full pipe accepts a new op in the same cycle the output drains.
- No bubbles under continuous flow. Ordering strictly FIFO.
- Held results: out_* stay stable while out_valid && !out_ready.
- n = 0, all ops except PASS: q = a, c = in_c.
- Ops for n > 0 (a = in_a, c = in_c):
  - SHL: q = a << n, zero fill; out_c = a[WIDTH-n].
  - SHR: q = a >> n, zero fill; out_c = a[n-1].
  - SAR: q = a >> n, fill with a[WIDTH-1]; out_c = a[n-1].
  - ROL: q = a rotated left n; out_c = q[0].
  - ROR: q = a rotated right n; out_c = q[WIDTH-1].
  - RCL: {out_c, q} = the (WIDTH+1)-bit value {c, a} rotated left n.
  - RCR: {q, out_c} = the (WIDTH+1)-bit value {a, c} rotated right n.
  - PASS: q = a, out_c = c, regardless of n.
- out_z is computed from the final q in the output stage.
- in_n is SHW bits wide, so amounts >= WIDTH cannot be expressed; there is no modulo behaviour for RCL/RCR beyond n <= WIDTH-1.
- Stage split when PIPE_MID=1:
  - Stage 1 applies the low ceil(SHW/2) amount bits, on a (WIDTH+1)-bit carry-extended working word.
  - Stage 2 applies the remaining bits, then flag logic.
  - Op, remaining amount bits, original sign bit, in_c and tag are registered with the partial word.
- Simultaneous input accept and output drain in one cycle are both honoured.

Decomposition:
- Shared package: op encodings (OP_SHL..OP_PASS) and the localparam helper for the stage split count. The same encodings are used by the decoder.
- One sub-module, shift_rotate_level: a single combinational mux level taking the (WIDTH+1)-bit working word, the op, one amount bit and the level index. It is instantiated SHW times via generate.
- Pipeline register and handshake logic stay in the top module.

Test Plan:
- SAR, a=0x80000010, n=4, c=1 -> q=0xF8000001, out_c=0, out_z=0.
- RCR, a=0x00000001, c=1, n=1 -> q=0x80000000, out_c=1. RCL, a=0x80000000, c=0, n=1 -> q=0x00000000, out_c=1, out_z=1.
- ROL, a=0x80000001, n=4 -> q=0x00000018, out_c=0. SHL, a=0x00000003, n=0, c=1 -> q=0x00000003, out_c=1.
- PIPE_MID=1, out_ready=0, three back-to-back ops with tags 1,2,3:
  - in_ready drops after tag 2 is accepted.
  - Release out_ready -> tags 1,2,3 emerge on consecutive cycles, in order, none lost or duplicated.
  - out_* stable while stalled.
- rst_n low mid-flight with out_valid=1 -> out_valid=0 and out_q=0 before the next clock edge. After release, the first new op appears with latency 1+PIPE_MID.
- Random sweep, WIDTH=8 and 32, PIPE_MID 0/1, random out_ready -> results match a reference model of all 8 ops and every n in 0..WIDTH-1.
